// File: rtl/fft_rx_if.sv
// FFT output stream bundle: valid/sop/eop framing, complex sample, ready back-pressure.
interface fft_rx_if #(
  parameter int DW = 16
);
  logic          source_valid;
  logic          source_sop;
  logic          source_eop;
  logic [DW-1:0] source_real;
  logic [DW-1:0] source_imag;
  logic          source_ready;

  modport master (
    output source_valid, source_sop, source_eop, source_real, source_imag,
    input  source_ready
  );

  modport slave (
    input  source_valid, source_sop, source_eop, source_real, source_imag,
    output source_ready
  );
endinterface

// File: rtl/fft_rx_ctrl.sv
// Receives FFT output frames into a bin buffer and holds each frame until acknowledged.
// Optional saturating framing-error counter enabled by macro FFT_RX_ERRCNT_EN.
module fft_rx_ctrl #(
  parameter int N  = 128,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_rx_if.slave              src,
  input  logic                 frame_ack,
  output logic                 wr_en,
  output logic [$clog2(N)-1:0] wr_addr,
  output logic [DW-1:0]        wr_real,
  output logic [DW-1:0]        wr_imag,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [7:0]           err_cnt
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

  state_t        state, state_next;
  logic [AW-1:0] idx, idx_next;
  logic          wr_en_next, done_next, err_next;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] real_next, imag_next;
  logic          accept;

  assign accept = src.source_valid && src.source_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    idx_next   = idx;
    wr_en_next = 1'b0;
    addr_next  = wr_addr;
    real_next  = wr_real;
    imag_next  = wr_imag;
    done_next  = 1'b0;
    err_next   = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept && src.source_sop) begin
          wr_en_next = 1'b1;
          addr_next  = '0;
          real_next  = src.source_real;
          imag_next  = src.source_imag;
          idx_next   = AW'(1);
          state_next = RECV;
        end
      end
      RECV: begin
        if (accept) begin
          if (src.source_sop) begin
            // A fresh sop restarts the frame and outranks a coincident eop.
            err_next   = 1'b1;
            wr_en_next = 1'b1;
            addr_next  = '0;
            real_next  = src.source_real;
            imag_next  = src.source_imag;
            idx_next   = AW'(1);
          end else if (src.source_eop && idx == LAST) begin
            wr_en_next = 1'b1;
            addr_next  = idx;
            real_next  = src.source_real;
            imag_next  = src.source_imag;
            done_next  = 1'b1;
            idx_next   = '0;
            state_next = HOLD;
          end else if (src.source_eop || idx == LAST) begin
            err_next   = 1'b1;
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            wr_en_next = 1'b1;
            addr_next  = idx;
            real_next  = src.source_real;
            imag_next  = src.source_imag;
            idx_next   = idx + AW'(1);
          end
        end
      end
      HOLD: begin
        if (frame_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      idx              <= '0;
      src.source_ready <= 1'b0;
      wr_en            <= 1'b0;
      wr_addr          <= '0;
      wr_real          <= '0;
      wr_imag          <= '0;
      frame_done       <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      state            <= state_next;
      idx              <= idx_next;
      src.source_ready <= (state_next != HOLD);
      wr_en            <= wr_en_next;
      wr_addr          <= addr_next;
      wr_real          <= real_next;
      wr_imag          <= imag_next;
      frame_done       <= done_next;
      frame_err        <= err_next;
    end
  end

`ifdef FFT_RX_ERRCNT_EN
  // Counts on the same edge that raises frame_err, so both are visible together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             err_cnt <= '0;
    else if (err_next && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule
